// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with a two-state data-memory handshake feeding the MEM/WB register.
// Define MEM_TIMEOUT_EN to add an abort timer on the REQ state (limit set by TIMEOUT_CYCLES).
//   state | meaning
//   IDLE  | accept ALU/link results in one cycle, or launch a memory op
//   REQ   | dmem_req held with stable addr/wdata/we until dmem_ack (or timeout)
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        link_en_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  dest_reg_in,
    input  logic [31:0] link_data_in,
    output logic        stall_o,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_reg_write,
    output logic [4:0]  wb_dest_reg,
    output logic [31:0] wb_data,
    output logic        dmem_timeout_err
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        mem_op;
    logic        capture;
    logic        timeout_hit;
    logic        mem_to_reg_q;
    logic        reg_write_q;
    logic        link_en_q;
    logic [4:0]  dest_q;
    logic [31:0] link_data_q;
    logic        wb_reg_write_nxt;
    logic [4:0]  wb_dest_nxt;
    logic [31:0] wb_data_nxt;

    assign mem_op = (mem_read_in | mem_write_in) & ~flush;

    always_comb begin
        state_nxt        = state;
        stall_o          = 1'b0;
        capture          = 1'b0;
        wb_reg_write_nxt = 1'b0;
        wb_dest_nxt      = wb_dest_reg;
        wb_data_nxt      = wb_data;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_o   = 1'b1;
                    capture   = 1'b1;
                    state_nxt = REQ;
                end else begin
                    wb_reg_write_nxt = reg_write_in & ~flush;
                    wb_dest_nxt      = dest_reg_in;
                    wb_data_nxt      = link_en_in ? link_data_in : alu_result_in;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    state_nxt        = IDLE;
                    wb_reg_write_nxt = reg_write_q;
                    wb_dest_nxt      = dest_q;
                    // dmem_addr doubles as the latched ALU result
                    wb_data_nxt      = mem_to_reg_q ? dmem_rdata
                                                    : (link_en_q ? link_data_q : dmem_addr);
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            link_en_q    <= 1'b0;
            dest_q       <= 5'd0;
            link_data_q  <= 32'd0;
            wb_reg_write <= 1'b0;
            wb_dest_reg  <= 5'd0;
            wb_data      <= 32'd0;
        end else begin
            state        <= state_nxt;
            dmem_req     <= (state_nxt == REQ);
            wb_reg_write <= wb_reg_write_nxt;
            wb_dest_reg  <= wb_dest_nxt;
            wb_data      <= wb_data_nxt;
            if (capture) begin
                dmem_we      <= mem_write_in;
                dmem_addr    <= alu_result_in;
                dmem_wdata   <= write_data_in;
                mem_to_reg_q <= mem_to_reg_in;
                reg_write_q  <= reg_write_in;
                // a combined read+write never selects the link value
                link_en_q    <= link_en_in & ~(mem_read_in & mem_write_in);
                link_data_q  <= link_data_in;
                dest_q       <= dest_reg_in;
            end else if (state_nxt == IDLE) begin
                dmem_we <= 1'b0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_err_q;

    assign timeout_hit      = (state == REQ) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign dmem_timeout_err = tmo_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= timeout_hit & ~dmem_ack;
            if ((state == REQ) && !dmem_ack && !timeout_hit)
                tmo_cnt <= tmo_cnt + 8'd1;
            else
                tmo_cnt <= 8'd0;
        end
    end
`else
    // timer compiled out: REQ waits for ack indefinitely; parameter stays referenced
    assign timeout_hit      = 1'b0 & (TIMEOUT_CYCLES > 0);
    assign dmem_timeout_err = 1'b0;
`endif

endmodule
